sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 60 ++++++
 tb/tb_sync_fifo.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags
module sync_fifo #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   level
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr, rd;
  assign full  = count[ADDR_WIDTH];
  assign empty = count == '0;
  assign level = count;
  assign dout  = mem[rd_ptr];
  assign wr    = write_en & ~full;
  assign rd    = read_en & ~empty;
  // storage: written at the tail, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally; count moves only when exactly one side is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, wr};
      rd_ptr <= rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, rd};
      count  <= count + {{ADDR_WIDTH{1'b0}}, wr} - {{ADDR_WIDTH{1'b0}}, rd};
    end
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // sticky error flags: any request against full/empty latches until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (write_en & full);
      underflow <= underflow | (read_en & empty);
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized queue-model bench for sync_fifo
module tb_sync_fifo;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 2 ** AW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] din = '0;
  logic write_en = 1'b0;
  logic read_en = 1'b0;
  logic [DW-1:0] dout;
  logic full, empty;
  logic [AW:0] level;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] q[$];
  logic ovf_m = 1'b0;
  logic unf_m = 1'b0;

  sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .din(din), .write_en(write_en), .read_en(read_en),
    .dout(dout), .full(full), .empty(empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("level", 32'(level), q.size());
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    if (q.size() != 0) check("dout", 32'(dout), 32'(q[0]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("underflow", 32'(underflow), 32'(unf_m));
`endif
  endtask

  task automatic step(input logic rs, input logic w, input logic r, input logic [DW-1:0] d);
    bit wa, ra;
    reset = rs;
    write_en = w;
    read_en = r;
    din = d;
    @(posedge clk);
    if (rs) begin
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (w && q.size() == DEPTH) ovf_m = 1'b1;
      if (r && q.size() == 0) unf_m = 1'b1;
      wa = w && q.size() < DEPTH;
      ra = r && q.size() > 0;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
    end
    #1;
    check_state();
  endtask

  initial begin
    int wv, rv, cyc;
    bit w, r;
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 1'b1, 8'h55);
    check("rst_dout", 32'(dout), 0);
    check("rst_empty", 32'(empty), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(full), 1);
    step(1'b0, 1'b1, 1'b0, 8'd4);
    check("drop_level", 32'(level), 4);
    for (int i = 0; i < 4; i++) begin
      check("drain_dout", 32'(dout), i);
      step(1'b0, 1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", 32'(empty), 1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("extra_rd_level", 32'(level), 0);
    wv = 0;
    rv = 0;
    cyc = 0;
    while ((wv < 100 || rv < 100) && cyc < 2000) begin
      w = wv < 100 && !full && $urandom_range(0, 3) != 0;
      r = !empty && $urandom_range(0, 3) != 0;
      if (r) begin
        check("stream", 32'(dout), rv);
        rv++;
      end
      step(1'b0, w, r, 8'(wv));
      if (w) wv++;
      cyc++;
    end
    check("stream_done", rv, 100);
    step(1'b0, 1'b1, 1'b0, 8'd10);
    step(1'b0, 1'b1, 1'b0, 8'd11);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'(20 + i));
    check("sim_level", 32'(level), 2);
    check("sim_order", 32'(dout), 21);
    step(1'b0, 1'b1, 1'b0, 8'd30);
    step(1'b0, 1'b1, 1'b0, 8'd31);
    check("sim_full", 32'(full), 1);
    step(1'b0, 1'b1, 1'b1, 8'd99);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("ovf_set", 32'(overflow), 1);
`endif
    check("sim_full_level", 32'(level), 3);
    while (q.size() != 0) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("unf_set", 32'(underflow), 1);
`endif
    check("sim_empty_level", 32'(level), 1);
    check("sim_empty_dout", 32'(dout), 32'h5A);
    step(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("flags_clr", 32'({overflow, underflow}), 0);
`endif
    check("mid_rst_level", 32'(level), 0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), 8'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
